// File: rtl/draw_pkg.sv
// Shared screen geometry, level codes and sequencer state type for the drawer-side VGA path.
package draw_pkg;

   localparam int X_SCREEN_PIXELS = 160;
   localparam int Y_SCREEN_PIXELS = 120;
   localparam int COLOUR_W        = 3;
   localparam int X_W             = $clog2(X_SCREEN_PIXELS);
   localparam int Y_W             = $clog2(Y_SCREEN_PIXELS);
   localparam int LEVEL_W         = 3;

   localparam logic [LEVEL_W-1:0] LEVEL_START  = 3'd0;
   localparam logic [LEVEL_W-1:0] LEVEL_1      = 3'd1;
   localparam logic [LEVEL_W-1:0] LEVEL_2      = 3'd2;
   localparam logic [LEVEL_W-1:0] LEVEL_3      = 3'd3;
   localparam logic [LEVEL_W-1:0] LEVEL_FINISH = 3'd4;
   // Never a real level, so the first frame after reset always repaints the background.
   localparam logic [LEVEL_W-1:0] LEVEL_NONE   = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_BG   = 3'd1,
      S_GAP  = 3'd2,
      S_SPR  = 3'd3,
      S_DONE = 3'd4
   } drawState_t;

   function automatic logic [COLOUR_W-1:0] selectColour(input logic useSprite,
                                                        input logic [COLOUR_W-1:0] bgColour,
                                                        input logic [COLOUR_W-1:0] sprColour);
      return useSprite ? sprColour : bgColour;
   endfunction

endpackage

// File: rtl/draw_pixel_pipe.sv
// Two-stage alignment of a drawer address with its one-cycle-late ROM colour, producing
// a registered (vgaX, vgaY, vgaColour, vgaPlot) stream.
module draw_pixel_pipe
   import draw_pkg::*;
(
   input  logic                Clock,
   input  logic                Reset,
   input  logic                inValid,
   input  logic                inSprite,
   input  logic [X_W-1:0]      inX,
   input  logic [Y_W-1:0]      inY,
   input  logic [COLOUR_W-1:0] bgColour,
   input  logic [COLOUR_W-1:0] sprColour,
   output logic [X_W-1:0]      vgaX,
   output logic [Y_W-1:0]      vgaY,
   output logic [COLOUR_W-1:0] vgaColour,
   output logic                vgaPlot
);

   logic           stage1Valid;
   logic           stage1Sprite;
   logic [X_W-1:0] stage1X;
   logic [Y_W-1:0] stage1Y;

   // Stage 1 holds the address while its colour arrives; stage 2 is the VGA-facing register.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         stage1Valid  <= 1'b0;
         stage1Sprite <= 1'b0;
         stage1X      <= {X_W{1'b0}};
         stage1Y      <= {Y_W{1'b0}};
         vgaX         <= {X_W{1'b0}};
         vgaY         <= {Y_W{1'b0}};
         vgaColour    <= {COLOUR_W{1'b0}};
         vgaPlot      <= 1'b0;
      end else begin
         stage1Valid  <= inValid;
         stage1Sprite <= inSprite;
         if (inValid) begin
            stage1X <= inX;
            stage1Y <= inY;
         end
         vgaPlot <= stage1Valid;
         if (stage1Valid) begin
            vgaX      <= stage1X;
            vgaY      <= stage1Y;
            vgaColour <= selectColour(stage1Sprite, bgColour, sprColour);
         end
      end
   end

endmodule

// File: rtl/draw_sequencer.sv
// Per-frame background/sprite draw sequencer and pixel stream mux for the VGA adapter.
// Optional build macro BG_EVERY_FRAME_EN: repaint the background on every frame, not only on level change.
module draw_sequencer
   import draw_pkg::*;
(
   input  logic                Clock,
   input  logic                Reset,
   input  logic                frameTick,
   input  logic [LEVEL_W-1:0]  currentLevel,
   input  logic [X_W-1:0]      backgroundX,
   input  logic [Y_W-1:0]      backgroundY,
   input  logic [COLOUR_W-1:0] backgroundColour,
   input  logic                backgroundDone,
   input  logic [X_W-1:0]      spriteX,
   input  logic [Y_W-1:0]      spriteY,
   input  logic [COLOUR_W-1:0] spriteColour,
   input  logic                spriteDone,
   output logic                backgroundSignal,
   output logic                spriteSignal,
   output logic [LEVEL_W-1:0]  levelLatched,
   output logic [X_W-1:0]      vgaX,
   output logic [Y_W-1:0]      vgaY,
   output logic [COLOUR_W-1:0] vgaColour,
   output logic                vgaPlot,
   output logic                busy,
   output logic                frameOverrun
);

   drawState_t         state, nextState;
   logic               pending, nextPending, overrunNext;
   logic [LEVEL_W-1:0] lastLevel, nextLastLevel, nextLevelLatched;
   logic               needBackground;
   logic               bgSignalQ, sprSignalQ;
   logic               bgValid, sprValid, pixValid, pixSprite;
   logic [X_W-1:0]     pixX;
   logic [Y_W-1:0]     pixY;

`ifdef BG_EVERY_FRAME_EN
   assign needBackground = 1'b1;
`else
   assign needBackground = (currentLevel != lastLevel);
`endif

   // Next state, one-deep frame-tick queue and level capture at frame start.
   always_comb begin
      nextState        = state;
      nextPending      = pending;
      overrunNext      = 1'b0;
      nextLastLevel    = lastLevel;
      nextLevelLatched = levelLatched;
      if (frameTick && (state != S_IDLE)) begin
         if (pending) begin
            overrunNext = 1'b1;
         end else begin
            nextPending = 1'b1;
         end
      end else begin
         overrunNext = 1'b0;
      end
      case (state)
         S_IDLE: begin
            if (frameTick || pending) begin
               nextLevelLatched = currentLevel;
               nextPending      = 1'b0;
               nextState        = needBackground ? S_BG : S_SPR;
            end else begin
               nextState = S_IDLE;
            end
         end
         S_BG: begin
            if (backgroundDone) begin
               nextLastLevel = levelLatched;
               nextState     = S_GAP;
            end else begin
               nextState = S_BG;
            end
         end
         S_GAP:   nextState = S_SPR;
         S_SPR: begin
            if (spriteDone) begin
               nextState = S_DONE;
            end else begin
               nextState = S_SPR;
            end
         end
         S_DONE:  nextState = S_IDLE;
         default: nextState = S_IDLE;
      endcase
   end

   // State and registered drawer requests; request outputs are decoded from the next state.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state            <= S_IDLE;
         pending          <= 1'b0;
         lastLevel        <= LEVEL_NONE;
         levelLatched     <= {LEVEL_W{1'b0}};
         backgroundSignal <= 1'b0;
         spriteSignal     <= 1'b0;
         busy             <= 1'b0;
         frameOverrun     <= 1'b0;
         bgSignalQ        <= 1'b0;
         sprSignalQ       <= 1'b0;
      end else begin
         state            <= nextState;
         pending          <= nextPending;
         lastLevel        <= nextLastLevel;
         levelLatched     <= nextLevelLatched;
         backgroundSignal <= (nextState == S_BG);
         spriteSignal     <= (nextState == S_SPR);
         busy             <= (nextState != S_IDLE);
         frameOverrun     <= overrunNext;
         bgSignalQ        <= backgroundSignal;
         sprSignalQ       <= spriteSignal;
      end
   end

   // The drawer spends the first request cycle initialising, so that address is not plotted.
   always_comb begin
      bgValid  = backgroundSignal & bgSignalQ & ~backgroundDone;
      sprValid = spriteSignal & sprSignalQ & ~spriteDone;
      if (spriteSignal) begin
         pixSprite = 1'b1;
         pixValid  = sprValid;
         pixX      = spriteX;
         pixY      = spriteY;
      end else begin
         pixSprite = 1'b0;
         pixValid  = bgValid;
         pixX      = backgroundX;
         pixY      = backgroundY;
      end
   end

   draw_pixel_pipe pipe (
      .Clock     (Clock),
      .Reset     (Reset),
      .inValid   (pixValid),
      .inSprite  (pixSprite),
      .inX       (pixX),
      .inY       (pixY),
      .bgColour  (backgroundColour),
      .sprColour (spriteColour),
      .vgaX      (vgaX),
      .vgaY      (vgaY),
      .vgaColour (vgaColour),
      .vgaPlot   (vgaPlot)
   );

endmodule

// File: tb/tb_draw_sequencer.sv
// Self-checking bench for draw_sequencer: behavioural drawers, frame scenario table and
// randomised sprite-only frames compared against an expected pixel list per frame.
module tb_draw_sequencer;
   import draw_pkg::*;

`ifdef BG_EVERY_FRAME_EN
   localparam bit EV = 1'b1;
`else
   localparam bit EV = 1'b0;
`endif
   localparam int M_NONE = 0, M_LVL = 1, M_RST = 2, M_DONE = 3, M_NOISE = 4;
   localparam int RAND_FRAMES = EV ? 0 : 8;

   typedef logic [17:0] pix_t;
   typedef struct {
      bit         doTick;
      logic [2:0] level;
      bit         expBg;
      int         mode;
      int         expOverrun;
   } vec_t;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic       frameTick = 1'b0;
   logic [2:0] currentLevel = 3'd0;

   logic [7:0] bgX, sprX, vgaX;
   logic [6:0] bgY, sprY, vgaY;
   logic [2:0] bgCol, sprCol, vgaColour, levelLatched;
   logic       bgActive, bgDone, sprActive, sprDone;
   logic       backgroundSignal, spriteSignal, vgaPlot, busy, frameOverrun;
   logic [7:0] sx0, sw, sprRx;
   logic [6:0] sy0, sh, sprRy;
   logic [2:0] sprSeed;

   int   total = 0, bad = 0, cyc = 0;
   int   overrunCnt, latchBad, bgFall, sprRise;
   bit   sawBg, prevBg = 1'b0, prevSpr = 1'b0;
   logic [2:0] frameLevel;
   pix_t gotQ[$], expQ[$];
   vec_t vecs[4];

   draw_sequencer dut (
      .Clock(Clock), .Reset(Reset), .frameTick(frameTick), .currentLevel(currentLevel),
      .backgroundX(bgX), .backgroundY(bgY), .backgroundColour(bgCol), .backgroundDone(bgDone),
      .spriteX(sprX), .spriteY(sprY), .spriteColour(sprCol), .spriteDone(sprDone),
      .backgroundSignal(backgroundSignal), .spriteSignal(spriteSignal), .levelLatched(levelLatched),
      .vgaX(vgaX), .vgaY(vgaY), .vgaColour(vgaColour), .vgaPlot(vgaPlot),
      .busy(busy), .frameOverrun(frameOverrun)
   );

   always #5 Clock = ~Clock;

   function automatic logic [2:0] bgRom(input logic [7:0] x, input logic [6:0] y);
      return x[2:0] ^ y[2:0] ^ {x[5], y[4], x[7]};
   endfunction

   function automatic logic [2:0] sprRom(input logic [7:0] x, input logic [6:0] y);
      return (x[2:0] + y[2:0]) ^ sprSeed;
   endfunction

   // Background drawer: one init cycle, then a raster scan, done held until the request drops.
   always @(posedge Clock) begin
      bgCol <= bgRom(bgX, bgY);
      if (!backgroundSignal) begin
         bgActive <= 1'b0; bgDone <= 1'b0; bgX <= 8'd0; bgY <= 7'd0;
      end else if (!bgActive) begin
         bgActive <= 1'b1;
      end else if (!bgDone) begin
         if (bgX == 8'd159 && bgY == 7'd119) bgDone <= 1'b1;
         else if (bgX == 8'd159) begin bgX <= 8'd0; bgY <= bgY + 7'd1; end
         else bgX <= bgX + 8'd1;
      end
   end

   // Sprite drawer: same handshake over a sw x sh rectangle at (sx0, sy0).
   always @(posedge Clock) begin
      sprCol <= sprRom(sprX, sprY);
      if (!spriteSignal) begin
         sprActive <= 1'b0; sprDone <= 1'b0; sprRx <= 8'd0; sprRy <= 7'd0;
      end else if (!sprActive) begin
         sprActive <= 1'b1;
      end else if (!sprDone) begin
         if (sprRx == sw - 8'd1 && sprRy == sh - 7'd1) sprDone <= 1'b1;
         else if (sprRx == sw - 8'd1) begin sprRx <= 8'd0; sprRy <= sprRy + 7'd1; end
         else sprRx <= sprRx + 8'd1;
      end
   end
   assign sprX = sx0 + sprRx;
   assign sprY = sy0 + sprRy;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return {6'd0, backgroundSignal, spriteSignal, levelLatched, vgaX, vgaY, vgaColour,
              vgaPlot, busy, frameOverrun};
   endfunction

   function automatic void buildExp(input bit withBg);
      expQ.delete();
      if (withBg)
         for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
               expQ.push_back({8'(x), 7'(y), bgRom(8'(x), 7'(y))});
      for (int r = 0; r < int'(sh); r++)
         for (int c = 0; c < int'(sw); c++) begin
            logic [7:0] px;
            logic [6:0] py;
            px = sx0 + 8'(c);
            py = sy0 + 7'(r);
            expQ.push_back({px, py, sprRom(px, py)});
         end
   endfunction

   function automatic int countMismatch();
      int m = 0;
      for (int i = 0; i < gotQ.size() && i < expQ.size(); i++)
         if (gotQ[i] !== expQ[i]) m++;
      return m;
   endfunction

   task automatic step();
      @(negedge Clock);
      cyc++;
      frameTick = 1'b0;
      if (vgaPlot) gotQ.push_back({vgaX, vgaY, vgaColour});
      if (frameOverrun) overrunCnt++;
      if (backgroundSignal) sawBg = 1'b1;
      if (prevBg && !backgroundSignal) bgFall = cyc;
      if (!prevSpr && spriteSignal) sprRise = cyc;
      if (busy && levelLatched !== frameLevel) latchBad++;
      prevBg  = backgroundSignal;
      prevSpr = spriteSignal;
   endtask

   task automatic runFrame(input vec_t v);
      int  n, waitCyc, idleBad;
      bit  aborted, doneTicked, lastSpr;
      gotQ.delete();
      overrunCnt = 0; latchBad = 0; bgFall = -1; sprRise = -1; sawBg = 1'b0;
      aborted = 1'b0; doneTicked = 1'b0;
      currentLevel = v.level;
      frameLevel   = v.level;
      sx0 = 8'($urandom_range(0, 150));
      sy0 = 7'($urandom_range(0, 110));
      sw  = 8'($urandom_range(1, 8));
      sh  = 7'($urandom_range(1, 8));
      sprSeed = 3'($urandom_range(0, 7));
      if (v.doTick) begin
         frameTick = 1'b1;
         step();
         check("bg_signal_first_cycle", backgroundSignal, v.expBg);
         check("spr_signal_first_cycle", spriteSignal, v.expBg ? 32'd0 : 32'd1);
      end else begin
         waitCyc = 0;
         do begin step(); waitCyc++; end while (!busy && waitCyc < 4);
         check("pending_start_latency", waitCyc, 1);
      end
      check("level_latched_start", levelLatched, v.level);
      lastSpr = spriteSignal;
      n = 0;
      while (busy && !aborted && n < 25000) begin
         step();
         n++;
         if (v.mode == M_LVL) begin
            if (bgX == 8'd40 && bgY == 7'd30) currentLevel = 3'd2;
            if ((bgX == 8'd60 && bgY == 7'd50) || (bgX == 8'd100 && bgY == 7'd90)) frameTick = 1'b1;
         end
         if (v.mode == M_DONE && lastSpr && !spriteSignal && busy && !doneTicked) begin
            frameTick  = 1'b1;
            doneTicked = 1'b1;
         end
         lastSpr = spriteSignal;
         if (v.mode == M_NOISE && n == 2) currentLevel = 3'($urandom_range(0, 6));
         if (v.mode == M_RST && bgX == 8'd80 && bgY == 7'd60) begin
            Reset = 1'b0;
            #1;
            check("reset_all_outputs_zero", outs(), 32'd0);
            buildExp(1'b1);
            check("abort_plot_count", gotQ.size(), 9679);
            check("abort_plot_data", countMismatch(), 0);
            step();
            step();
            Reset = 1'b1;
            idleBad = 0;
            repeat (5) begin
               step();
               if (busy || vgaPlot || backgroundSignal || spriteSignal) idleBad++;
            end
            check("idle_after_reset", idleBad, 0);
            aborted = 1'b1;
         end
      end
      if (v.mode == M_RST) check("reset_point_reached", aborted, 1);
      if (!aborted) begin
         check("frame_end", busy, 0);
         buildExp(v.expBg);
         check("plot_count", gotQ.size(), expQ.size());
         check("plot_data", countMismatch(), 0);
         check("bg_requested", sawBg, v.expBg);
         check("overrun_pulses", overrunCnt, v.expOverrun);
         check("level_stable", latchBad, 0);
         check("level_held_end", levelLatched, v.level);
         if (v.mode == M_DONE) check("done_tick_issued", doneTicked, 1);
         if (v.expBg) begin
            check("gap_cycles", sprRise - bgFall, 1);
            if (gotQ.size() >= 19200) begin
               check("first_bg_pixel", gotQ[0][17:3], {8'd0, 7'd0});
               check("last_bg_pixel", gotQ[19199][17:3], {8'd159, 7'd119});
            end else begin
               check("bg_plot_span", gotQ.size(), 19200);
            end
         end
      end
      currentLevel = v.level;
   endtask

   initial begin
      vec_t rv;
      vecs[0] = '{1'b1, 3'd1, 1'b1, M_LVL,  1};
      vecs[1] = '{1'b0, 3'd2, 1'b1, M_RST,  0};
      vecs[2] = '{1'b1, 3'd2, 1'b1, M_DONE, 0};
      vecs[3] = '{1'b0, 3'd2, EV,   M_NONE, 0};
      frameLevel = 3'd0;
      step();
      step();
      check("reset_outputs", outs(), 32'd0);
      Reset = 1'b1;
      step();
      step();
      check("idle_after_release", outs(), 32'd0);
      for (int i = 0; i < 4; i++) runFrame(vecs[i]);
      for (int i = 0; i < RAND_FRAMES; i++) begin
         rv = '{1'b1, 3'd2, EV, M_NOISE, 0};
         repeat ($urandom_range(1, 4)) step();
         runFrame(rv);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
